// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO: one enqueue and one dequeue per cycle, one-cycle enqueue-to-visible latency.
// Backpressure: enq_ready_o is registered not-full only, independent of deq_ready_i; flush drops all entries.
module inst_queue #(
   parameter int DEPTH    = 4,
   parameter int PTR_W    = $clog2(DEPTH),
   parameter int INSN_LEN = 32,
   parameter int ADDR_LEN = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                enq_valid_i,
   output logic                enq_ready_o,
   input  logic [INSN_LEN-1:0] enq_inst_i,
   input  logic [ADDR_LEN-1:0] enq_pc_i,
   output logic                deq_valid_o,
   input  logic                deq_ready_i,
   output logic [INSN_LEN-1:0] deq_inst_o,
   output logic [ADDR_LEN-1:0] deq_pc_o,
   output logic [PTR_W:0]      count_o
);

   localparam logic [PTR_W:0]      CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [INSN_LEN-1:0] NOP      = INSN_LEN'(32'h0000_0013);

   logic [INSN_LEN-1:0] inst_mem [DEPTH];
   logic [ADDR_LEN-1:0] pc_mem   [DEPTH];
   logic [PTR_W-1:0]    head;
   logic [PTR_W-1:0]    tail;
   logic [PTR_W:0]      count;
   logic                enq_fire;
   logic                deq_fire;

   assign enq_ready_o = (count != CNT_FULL);
   assign deq_valid_o = (count != '0);
   assign count_o     = count;

   assign enq_fire = enq_valid_i && enq_ready_o && !flush_i;
   assign deq_fire = deq_valid_o && deq_ready_i && !flush_i;

   // Empty queue presents a NOP so stale or unwritten storage never reaches decode.
   always_comb begin
      deq_inst_o = NOP;
      deq_pc_o   = '0;
      if (deq_valid_o) begin
         deq_inst_o = inst_mem[head];
         deq_pc_o   = pc_mem[head];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq_fire)
            tail <= tail + PTR_W'(1);
         if (deq_fire)
            head <= head + PTR_W'(1);
         if (enq_fire && !deq_fire)
            count <= count + (PTR_W+1)'(1);
         else if (deq_fire && !enq_fire)
            count <= count - (PTR_W+1)'(1);
      end
   end

   // Storage has no reset; validity is tracked solely by count.
   always_ff @(posedge clk_i) begin
      if (enq_fire) begin
         inst_mem[tail] <= enq_inst_i;
         pc_mem[tail]   <= enq_pc_i;
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=4): vector table plus streaming, wrap and mid-operation reset sequences.
module tb_inst_queue;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        enq_valid;
   logic        enq_ready;
   logic [31:0] enq_inst;
   logic [31:0] enq_pc;
   logic        deq_valid;
   logic        deq_ready;
   logic [31:0] deq_inst;
   logic [31:0] deq_pc;
   logic [2:0]  count;

   int checks   = 0;
   int failures = 0;

   inst_queue #(.DEPTH(4)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .flush_i     (flush),
      .enq_valid_i (enq_valid),
      .enq_ready_o (enq_ready),
      .enq_inst_i  (enq_inst),
      .enq_pc_i    (enq_pc),
      .deq_valid_o (deq_valid),
      .deq_ready_i (deq_ready),
      .deq_inst_o  (deq_inst),
      .deq_pc_o    (deq_pc),
      .count_o     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic        ev;
      logic [31:0] inst;
      logic [31:0] pc;
      logic        dr;
      logic [2:0]  x_cnt;
      logic        x_er;
      logic        x_dv;
      logic [31:0] x_inst;
      logic [31:0] x_pc;
   } vec_t;

   function automatic vec_t mk(input logic fl, input logic ev, input logic [31:0] inst,
                               input logic [31:0] pc, input logic dr, input logic [2:0] x_cnt,
                               input logic x_er, input logic x_dv, input logic [31:0] x_inst,
                               input logic [31:0] x_pc);
      vec_t v;
      v.fl = fl; v.ev = ev; v.inst = inst; v.pc = pc; v.dr = dr;
      v.x_cnt = x_cnt; v.x_er = x_er; v.x_dv = x_dv; v.x_inst = x_inst; v.x_pc = x_pc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [2:0] c, input logic er, input logic dv,
                             input logic [31:0] i, input logic [31:0] p);
      check({tag, "_count"}, 32'(count), 32'(c));
      check({tag, "_enq_ready"}, 32'(enq_ready), 32'(er));
      check({tag, "_deq_valid"}, 32'(deq_valid), 32'(dv));
      check({tag, "_deq_inst"}, deq_inst, i);
      check({tag, "_deq_pc"}, deq_pc, p);
   endtask

   task automatic cyc(input logic fl, input logic ev, input logic [31:0] inst,
                      input logic [31:0] pc, input logic dr);
      flush = fl; enq_valid = ev; enq_inst = inst; enq_pc = pc; deq_ready = dr;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[16];
   logic [31:0] q_inst[$];
   logic [31:0] q_pc[$];

   initial begin
      // inputs                         expected after the edge
      vecs[0]  = mk(0,1,32'h00A00093,32'h1000,0, 1,1,1,32'h00A00093,32'h1000);
      vecs[1]  = mk(0,1,32'h00B00113,32'h1004,0, 2,1,1,32'h00A00093,32'h1000);
      vecs[2]  = mk(0,1,32'h00C00193,32'h1008,0, 3,1,1,32'h00A00093,32'h1000);
      vecs[3]  = mk(0,1,32'h00D00213,32'h100C,0, 4,0,1,32'h00A00093,32'h1000);
      vecs[4]  = mk(0,1,32'h00E00293,32'h1010,0, 4,0,1,32'h00A00093,32'h1000);
      vecs[5]  = mk(0,1,32'h00E00293,32'h1010,1, 3,1,1,32'h00B00113,32'h1004);
      vecs[6]  = mk(0,0,32'h0,       32'h0,   1, 2,1,1,32'h00C00193,32'h1008);
      vecs[7]  = mk(0,0,32'h0,       32'h0,   1, 1,1,1,32'h00D00213,32'h100C);
      vecs[8]  = mk(0,0,32'h0,       32'h0,   1, 0,1,0,NOP,        32'h0);
      vecs[9]  = mk(0,0,32'h0,       32'h0,   1, 0,1,0,NOP,        32'h0);
      vecs[10] = mk(0,1,32'h00A00093,32'h1000,1, 1,1,1,32'h00A00093,32'h1000);
      vecs[11] = mk(0,1,32'h00B00113,32'h1004,0, 2,1,1,32'h00A00093,32'h1000);
      vecs[12] = mk(0,1,32'h00C00193,32'h1008,0, 3,1,1,32'h00A00093,32'h1000);
      vecs[13] = mk(1,1,32'h00E00293,32'h1010,1, 0,1,0,NOP,        32'h0);
      vecs[14] = mk(0,1,32'h00100093,32'h2000,0, 1,1,1,32'h00100093,32'h2000);
      vecs[15] = mk(0,0,32'h0,       32'h0,   1, 0,1,0,NOP,        32'h0);

      rst_n = 1'b0; flush = 0; enq_valid = 0; enq_inst = '0; enq_pc = '0; deq_ready = 0;
      #1;
      check_outs("in_reset", 3'd0, 1'b1, 1'b0, NOP, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_outs("idle", 3'd0, 1'b1, 1'b0, NOP, 32'h0);

      for (int i = 0; i < 16; i++) begin
         cyc(vecs[i].fl, vecs[i].ev, vecs[i].inst, vecs[i].pc, vecs[i].dr);
         check_outs($sformatf("v%0d", i), vecs[i].x_cnt, vecs[i].x_er, vecs[i].x_dv,
                    vecs[i].x_inst, vecs[i].x_pc);
      end

      // Streaming at count=2 with a reference queue; pointers wrap several times.
      for (int i = 0; i < 18; i++) begin
         logic        ev, dr, ef, df;
         logic [31:0] ins, pc;
         ev  = 1'b1;
         dr  = (i >= 2) && (i < 12);
         if (i >= 12) ev = 1'b0;
         if (i >= 12) dr = 1'b1;
         ins = 32'h0300_0013 + 32'(i) * 32'h100;
         pc  = 32'h3000 + 32'(i) * 4;
         ef  = ev && (q_inst.size() < 4);
         df  = dr && (q_inst.size() > 0);
         cyc(1'b0, ev, ins, pc, dr);
         if (df) begin
            void'(q_inst.pop_front());
            void'(q_pc.pop_front());
         end
         if (ef) begin
            q_inst.push_back(ins);
            q_pc.push_back(pc);
         end
         check($sformatf("s%0d_count", i), 32'(count), 32'(q_inst.size()));
         check($sformatf("s%0d_deq_valid", i), 32'(deq_valid), 32'(q_inst.size() != 0));
         check($sformatf("s%0d_deq_inst", i), deq_inst, (q_inst.size() != 0) ? q_inst[0] : NOP);
         check($sformatf("s%0d_deq_pc", i), deq_pc, (q_pc.size() != 0) ? q_pc[0] : 32'h0);
      end

      // Reset asserted mid-cycle clears state without waiting for an edge.
      cyc(1'b0, 1'b1, 32'h00500013, 32'h4000, 1'b0);
      cyc(1'b0, 1'b1, 32'h00600013, 32'h4004, 1'b0);
      check_outs("pre_rst", 3'd2, 1'b1, 1'b1, 32'h00500013, 32'h4000);
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("mid_rst", 3'd0, 1'b1, 1'b0, NOP, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b0, 1'b1, 32'h00700013, 32'h5000, 1'b0);
      check_outs("post_rst", 3'd1, 1'b1, 1'b1, 32'h00700013, 32'h5000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the fetch stage and the decode stage, feeding the instruction word and PC that the decoder and immediate decoder consume. It is a parameterised single-enqueue, single-dequeue FIFO with valid/ready handshakes on both sides. It absorbs fetch/decode rate mismatch, and a flush input drops all queued instructions on redirect (branch mispredict, exception).

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; must be a power of two, ≥ 2.
- `PTR_W`, default $clog2(DEPTH): pointer width.

Ports:
- `clk_i`  input  1  single clock; all state updates on the rising edge.
- `rst_ni`  input  1  asynchronous, active-low reset.
- `flush_i`  input  1  synchronous flush; empties the queue.
- `enq_valid_i`  input  1  fetch presents an instruction.
- `enq_ready_o`  output  1  queue can accept an instruction; equals not-full.
- `enq_inst_i`  input  `INSN_LEN`  instruction word.
- `enq_pc_i`  input  `ADDR_LEN`  PC of the instruction.
- `deq_valid_o`  output  1  head entry valid; equals not-empty.
- `deq_ready_i`  input  1  decode accepts the head entry.
- `deq_inst_o`  output  `INSN_LEN`  head instruction word; NOP (32'h0000_0013) when empty.
- `deq_pc_o`  output  `ADDR_LEN`  head PC; 0 when empty.
- `count_o`  output  PTR_W+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {inst, pc}, plus head pointer, tail pointer and count register.
- Enqueue fire: `enq_valid_i && enq_ready_o && !flush_i`. Writes {inst, pc} at tail and increments tail modulo DEPTH.
- Dequeue fire: `deq_valid_o && deq_ready_i && !flush_i`. Increments head modulo DEPTH.
- Count update: +1 on enqueue only, −1 on dequeue only, unchanged when both fire or neither fires.
- `enq_ready_o = (count != DEPTH)`. It is derived only from registered state and never depends on `deq_ready_i`. A full queue rejects the enqueue even if a dequeue fires in the same cycle.
- `deq_valid_o = (count != 0)`. There is no enqueue-to-dequeue bypass; an instruction written into an empty queue is visible the next cycle.
- `deq_inst_o` and `deq_pc_o` read combinationally from the head entry when not empty. When empty they output NOP and 0.
- Flush:
  - Head, tail and count go to 0 on the next edge.
  - Any enqueue or dequeue in the flush cycle is discarded; the entry is neither written nor consumed.
  - Entry storage is not cleared.
- Pointer wrap: pointers are PTR_W bits and wrap naturally from DEPTH−1 to 0. Full/empty is decided by count, never by pointer equality.
- Inputs with valid low are don't-care; no X propagates to the outputs when the queue is empty.

## Timing
- Reset (`rst_ni` low, asynchronous): head = tail = count = 0. Outputs during and after reset:
  - `enq_ready_o` = 1
  - `deq_valid_o` = 0
  - `deq_inst_o` = 32'h0000_0013
  - `deq_pc_o` = 0
  - `count_o` = 0
- Reset deassertion is synchronised externally; the first enqueue can fire on the first edge after release.
- Latency: one cycle from enqueue fire to `deq_valid_o` high for that entry (empty-queue case).
- Throughput: one enqueue and one dequeue per cycle sustained when 0 < count < DEPTH.
- Handshake rules:
  - Fetch must hold `enq_*` stable while `enq_valid_i` is high and `enq_ready_o` is low.
  - Head outputs stay stable until a dequeue fires or a flush occurs.
- Flush takes effect at the edge ending the flush cycle. The following cycle shows the empty outputs, and enqueue is accepted in that cycle.
- Reset asserted mid-operation clears state immediately, regardless of any in-flight handshake.

## Test plan
- Reset/idle: hold `rst_ni` = 0, then release → `count_o` = 0, `deq_valid_o` = 0, `deq_inst_o` = 32'h0000_0013, `enq_ready_o` = 1.
- Fill and drain, DEPTH = 4, `deq_ready_i` = 0:
  - Enqueue inst 0x00A00093, 0x00B00113, 0x00C00193, 0x00D00213 with PC 0x1000..0x100C → `count_o` = 4 and `enq_ready_o` = 0.
  - A fifth `enq_valid_i` is held off.
  - Then `deq_ready_i` = 1 → outputs appear in order with matching PCs, and `deq_valid_o` drops after the fourth dequeue.
- Simultaneous enqueue/dequeue at count = 2 for 10 cycles → count stays 2, data order preserved.
- Pointer wrap: the same stream runs long enough for pointers to cross DEPTH−1 → 0 → no loss or reordering.
- Full plus simultaneous dequeue: count = 4, both `enq_valid_i` and `deq_ready_i` high → the dequeue fires, the enqueue is rejected, and count = 3 next cycle.
- Flush:
  - count = 3, assert `flush_i` together with `enq_valid_i` and `deq_ready_i` → next cycle count = 0, `deq_valid_o` = 0, and the flushed-cycle enqueue never appears.
  - Enqueue PC 0x2000 in the next cycle → it is at the head one cycle later.
